// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions: EX_WB bundle field positions and writeback FSM encodings.
package writeback_stage_pkg;

  localparam int RESULT_LSB = 0;
  localparam int PC_LSB     = 32;
  localparam int BR_BIT     = 65;
  localparam int WE_BIT     = 66;
  localparam int DEST_LSB   = 67;
  localparam int EXWB_W     = 100;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_register_file.sv
// Register file with two combinational read ports, one write port, r0 tied to zero
// and same-cycle write-through so decode sees a result in the cycle it commits.
import writeback_stage_pkg::*;

module register_file #(
  parameter int REG_COUNT = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data
);

  logic [REG_COUNT-1:0][DATA_W-1:0] rf_flat;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : gen_reg
      if (gi == 0) begin : gen_zero
        assign rf_flat[gi] = '0;
      end else begin : gen_word
        logic [DATA_W-1:0] word_reg;

        always_ff @(posedge clock) begin
          if (reset) begin
            word_reg <= '0;
          end else if (wr_en && (wr_addr == REG_ADDR_W'(gi))) begin
            word_reg <= wr_data;
          end
        end

        assign rf_flat[gi] = word_reg;
      end
    end
  endgenerate

  // wr_en is only raised for non-zero destinations, so the bypass never hides r0
  always_comb begin
    rs_data = '0;
    if (rs_addr != '0) begin
      if (wr_en && (wr_addr == rs_addr)) begin
        rs_data = wr_data;
      end else begin
        rs_data = rf_flat[rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != '0) begin
      if (wr_en && (wr_addr == rt_addr)) begin
        rt_data = wr_data;
      end else begin
        rt_data = rf_flat[rt_addr];
      end
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits EX_WB results, issues branch redirects to fetch,
// squashes the wrong-path bundles behind a taken branch and counts retirements.
import writeback_stage_pkg::*;

module writeback_stage #(
  parameter int SQUASH_CYCLES = 2,
  parameter int REG_COUNT     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [EXWB_W-1:0]     EX_WB,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic                  pc_redirect,
  output logic [DATA_W-1:0]     pc_target,
  output logic                  squashing,
  output logic [DATA_W-1:0]     retire_count
);

  localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES);

  logic [DATA_W-1:0]     ex_result;
  logic [DATA_W-1:0]     ex_pc;
  logic                  ex_branch;
  logic                  ex_wr_en;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  unused_reserved;

  assign ex_result       = EX_WB[RESULT_LSB +: DATA_W];
  assign ex_pc           = EX_WB[PC_LSB +: DATA_W];
  assign ex_branch       = EX_WB[BR_BIT];
  assign ex_wr_en        = EX_WB[WE_BIT];
  assign ex_dest         = EX_WB[DEST_LSB +: REG_ADDR_W];
  assign unused_reserved = ^{EX_WB[EXWB_W-1:DEST_LSB+REG_ADDR_W], EX_WB[PC_LSB+DATA_W]};

  wb_state_e         state_reg;
  logic [2:0]        squash_cnt_reg;
  logic              pc_redirect_reg;
  logic [DATA_W-1:0] pc_target_reg;
  logic [DATA_W-1:0] retire_count_reg;

  logic accept;
  logic commit;

  assign accept = ex_valid && (state_reg == RUN);
  assign commit = accept && ex_wr_en && (ex_dest != '0);

  register_file #(
    .REG_COUNT (REG_COUNT)
  ) u_register_file (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (commit),
    .wr_addr (ex_dest),
    .wr_data (ex_result),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= RUN;
      squash_cnt_reg   <= '0;
      pc_redirect_reg  <= 1'b0;
      pc_target_reg    <= '0;
      retire_count_reg <= '0;
    end else begin
      pc_redirect_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (ex_valid) begin
            retire_count_reg <= retire_count_reg + 1'b1;
            if (ex_branch) begin
              pc_redirect_reg <= 1'b1;
              pc_target_reg   <= ex_pc;
              if (SQUASH_CYCLES > 0) begin
                state_reg      <= SQUASH;
                squash_cnt_reg <= SQUASH_LOAD;
              end
            end
          end
        end
        SQUASH: begin
          // only valid bundles consume squash slots; bubbles pass through untouched
          if (ex_valid) begin
            squash_cnt_reg <= squash_cnt_reg - 1'b1;
            if (squash_cnt_reg == 3'd1) begin
              state_reg <= RUN;
            end
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign pc_redirect  = pc_redirect_reg;
  assign pc_target    = pc_target_reg;
  assign squashing    = (state_reg == SQUASH);
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a reference model predicts each cycle's outputs,
// queues them at drive time and compares after the clock edge.
module tb_writeback_stage;

  localparam int SQ = 2;

  logic         clock;
  logic         reset;
  logic         ex_valid;
  logic [99:0]  EX_WB;
  logic [4:0]   rs_addr;
  logic [4:0]   rt_addr;
  logic [31:0]  rs_data;
  logic [31:0]  rt_data;
  logic         pc_redirect;
  logic [31:0]  pc_target;
  logic         squashing;
  logic [31:0]  retire_count;

  writeback_stage #(
    .SQUASH_CYCLES (SQ),
    .REG_COUNT     (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .EX_WB        (EX_WB),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .pc_redirect  (pc_redirect),
    .pc_target    (pc_target),
    .squashing    (squashing),
    .retire_count (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        redirect;
    logic [31:0] target;
    logic        squash;
    logic [31:0] retire;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_rf [32];
  logic        m_sq;
  int          m_cnt;
  logic        m_redir;
  logic [31:0] m_target;
  logic [31:0] m_retire;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic com,
                                             input logic [4:0] d, input logic [31:0] r);
    if (a == 5'd0) return 32'h0;
    if (com && d == a) return r;
    return m_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_sq = 1'b0; m_cnt = 0; m_redir = 1'b0; m_target = 32'h0; m_retire = 32'h0;
  endtask

  task automatic pop_and_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_redirect"}, {31'd0, pc_redirect}, {31'd0, e.redirect});
    check_eq({tag, "_target"},   pc_target, e.target);
    check_eq({tag, "_squashing"}, {31'd0, squashing}, {31'd0, e.squash});
    check_eq({tag, "_retire"},   retire_count, e.retire);
    $display("txn %s: redirect=%0d target=0x%08h squashing=%0d retire=%0d",
             tag, pc_redirect, pc_target, squashing, retire_count);
  endtask

  // One pipeline cycle: drive, check same-cycle reads (bypass), predict, clock, compare.
  task automatic cycle(input string tag, input logic v, input logic br, input logic we,
                       input logic [4:0] dest, input logic [31:0] res, input logic [31:0] pc,
                       input logic [4:0] ra, input logic [4:0] rb);
    logic acc, com;
    exp_t e;
    @(negedge clock);
    ex_valid = v;
    EX_WB    = {$urandom(), 4'h0, $urandom(), 1'b0, 4'h0} << 72;
    EX_WB[31:0]  = res;
    EX_WB[63:32] = pc;
    EX_WB[64]    = 1'($urandom());
    EX_WB[65]    = br;
    EX_WB[66]    = we;
    EX_WB[71:67] = dest;
    rs_addr = ra;
    rt_addr = rb;
    acc = v && !m_sq;
    com = acc && we && (dest != 5'd0);
    #1;
    check_eq({tag, "_rs"}, rs_data, model_read(ra, com, dest, res));
    check_eq({tag, "_rt"}, rt_data, model_read(rb, com, dest, res));
    m_redir = 1'b0;
    if (acc) begin
      m_retire = m_retire + 32'd1;
      if (com) m_rf[dest] = res;
      if (br) begin
        m_redir  = 1'b1;
        m_target = pc;
        if (SQ > 0) begin
          m_sq  = 1'b1;
          m_cnt = SQ;
        end
      end
    end else if (v && m_sq) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_sq = 1'b0;
    end
    e.redirect = m_redir; e.target = m_target; e.squash = m_sq; e.retire = m_retire;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    pop_and_compare(tag);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clock);
    reset = 1'b1;
    ex_valid = 1'b0;
    model_reset();
    e.redirect = 1'b0; e.target = 32'h0; e.squash = 1'b0; e.retire = 32'h0;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    pop_and_compare(tag);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; EX_WB = '0; rs_addr = '0; rt_addr = '0;
    model_reset();
    repeat (2) @(posedge clock);
    do_reset("reset");
    cycle("reset_read", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);

    // basic write then read-back
    cycle("wr5", 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0010, 32'h0, 5'd1, 5'd2);
    cycle("rd5", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);

    // same-cycle bypass
    cycle("byp7", 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd7);
    cycle("rd7", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd5);

    // r0 stays zero, count still advances
    cycle("wr0", 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
    cycle("rd0", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7);

    // branch with write, bubble, two dropped bundles (one a branch), third commits
    cycle("br40",  1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0333, 32'h0000_0040, 5'd3, 5'd0);
    cycle("bub",   1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0999, 32'h0, 5'd3, 5'd9);
    cycle("drop1", 1'b1, 1'b1, 1'b1, 5'd9, 32'h1111_1111, 32'h0000_0080, 5'd9, 5'd3);
    cycle("drop2", 1'b1, 1'b0, 1'b1, 5'd9, 32'h2222_2222, 32'h0, 5'd9, 5'd0);
    cycle("com3",  1'b1, 1'b0, 1'b1, 5'd9, 32'h3333_3333, 32'h0, 5'd9, 5'd5);
    cycle("rd9",   1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd3);

    // reset while one squash slot remains
    cycle("br100", 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_0100, 5'd0, 5'd0);
    cycle("dropA", 1'b1, 1'b0, 1'b1, 5'd4, 32'h4444_4444, 32'h0, 5'd4, 5'd0);
    do_reset("rst_sq");
    cycle("postrst", 1'b1, 1'b0, 1'b1, 5'd4, 32'h5555_5555, 32'h0, 5'd4, 5'd9);
    cycle("rd4", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd9);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom()), 5'($urandom()), $urandom(), $urandom(),
            5'($urandom()), 5'($urandom()));
    end
    do_reset("rst2");

    // counter wrap via force
    @(negedge clock);
    force dut.retire_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_reg;
    m_retire = 32'hFFFF_FFFF;
    #1;
    check_eq("preload", retire_count, 32'hFFFF_FFFF);
    cycle("wrap", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
